// File: rtl/sap1_ctrl_pkg.sv
// Shared definitions for the SAP-1 controller-sequencer.
//  - opcode values, ring-state encodings, control-word layout
//  - one-hot test helper used by the ring counter
package sap1_ctrl_pkg;

    localparam int unsigned OP_W     = 4;
    localparam int unsigned T_STATES = 6;
    localparam int unsigned CON_W    = 12;

    localparam logic [OP_W-1:0] OP_LDA = 4'h0;
    localparam logic [OP_W-1:0] OP_ADD = 4'h1;
    localparam logic [OP_W-1:0] OP_SUB = 4'h2;
    localparam logic [OP_W-1:0] OP_OUT = 4'hE;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;

    typedef logic [T_STATES-1:0] t_state_t;

    localparam t_state_t T1 = 6'b000001;
    localparam t_state_t T2 = 6'b000010;
    localparam t_state_t T3 = 6'b000100;
    localparam t_state_t T4 = 6'b001000;
    localparam t_state_t T5 = 6'b010000;
    localparam t_state_t T6 = 6'b100000;

    // Bit 11 (cp) down to bit 0 (lo_n)
    typedef struct packed {
        logic cp;
        logic ep;
        logic lm_n;
        logic ce_n;
        logic li_n;
        logic ei_n;
        logic la_n;
        logic ea;
        logic su;
        logic eu;
        logic lb_n;
        logic lo_n;
    } con_word_t;

    localparam logic [CON_W-1:0] CON_NOP = 12'h3E3;

    // True only for exactly one bit set; X input yields a non-true result
    function automatic logic is_onehot(input t_state_t t);
        return (t != '0) && ((t & (t - T_STATES'(1))) == '0);
    endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// Six-state one-hot ring counter, advancing on the falling clock edge.
//  CLK  in  clock; ring rotates on negedge
//  CLR  in  asynchronous active-high reset to T1
//  hold in  freeze the ring (halt)
//  T    out one-hot state, T[0]=T1 .. T[5]=T6
module sap1_ring_counter
    import sap1_ctrl_pkg::*;
(
    input  logic                CLK,
    input  logic                CLR,
    input  logic                hold,
    output logic [T_STATES-1:0] T
);

    // A corrupted (non-one-hot or X) state falls into the else branch and restarts at T1
    always_ff @(negedge CLK or posedge CLR) begin
        if (CLR) begin
            T <= T1;
        end else if (is_onehot(T)) begin
            if (!hold) begin
                T <= {T[T_STATES-2:0], T[T_STATES-1]};
            end
        end else begin
            T <= T1;
        end
    end

endmodule

// File: rtl/sap1_controller.sv
// SAP-1 controller-sequencer: ring counter plus microcode decode of the IR opcode.
//  CLK    in  system clock; sequencing on negedge so CON is stable at posedge
//  CLR    in  asynchronous active-high reset
//  opcode in  IR[7:4], meaningful from T4 onward
//  CON    out control word {Cp,Ep,Lm_n,CE_n,Li_n,Ei_n,La_n,Ea,Su,Eu,Lb_n,Lo_n}
//  T      out one-hot ring state
//  HLT    out halt indication
module sap1_controller
    import sap1_ctrl_pkg::*;
(
    input  logic                CLK,
    input  logic                CLR,
    input  logic [OP_W-1:0]     opcode,
    output logic [CON_W-1:0]    CON,
    output logic [T_STATES-1:0] T,
    output logic                HLT
);

    logic      halted;
    logic      hlt_c;
    con_word_t con_c;

    // Halt is visible during T4 of HLT and also freezes the ring on the edge ending T4
    assign hlt_c = halted | (T[3] & (opcode == OP_HLT));
    assign HLT   = hlt_c;
    assign CON   = con_c;

    sap1_ring_counter u_ring (
        .CLK  (CLK),
        .CLR  (CLR),
        .hold (hlt_c),
        .T    (T)
    );

    // Sticky halt, cleared only by CLR
    always_ff @(negedge CLK or posedge CLR) begin
        if (CLR) begin
            halted <= 1'b0;
        end else if (hlt_c) begin
            halted <= 1'b1;
        end
    end

    // Microcode: start from the idle word and enable only the fields each step needs
    always_comb begin
        con_c = con_word_t'(CON_NOP);
        if (!halted) begin
            case (T)
                T1: begin
                    con_c.ep   = 1'b1;
                    con_c.lm_n = 1'b0;
                end
                T2: begin
                    con_c.cp   = 1'b1;
                end
                T3: begin
                    con_c.ce_n = 1'b0;
                    con_c.li_n = 1'b0;
                end
                T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            con_c.ei_n = 1'b0;
                            con_c.lm_n = 1'b0;
                        end
                        OP_OUT: begin
                            con_c.ea   = 1'b1;
                            con_c.lo_n = 1'b0;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    case (opcode)
                        OP_LDA: begin
                            con_c.ce_n = 1'b0;
                            con_c.la_n = 1'b0;
                        end
                        OP_ADD: begin
                            con_c.ce_n = 1'b0;
                            con_c.lb_n = 1'b0;
                        end
                        OP_SUB: begin
                            con_c.ce_n = 1'b0;
                            con_c.lb_n = 1'b0;
                            con_c.su   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    case (opcode)
                        OP_ADD: begin
                            con_c.la_n = 1'b0;
                            con_c.eu   = 1'b1;
                        end
                        OP_SUB: begin
                            con_c.la_n = 1'b0;
                            con_c.su   = 1'b1;
                            con_c.eu   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
